// File: rtl/perip_wr_arb_if.sv
// ---------------------------------------------------------------------------
// perip_wr_arb_if
//   Bundles the handshake and bus signals of the peripheral write arbiter.
//
//   Handshake: a requester raises req_i[k] and holds addr_i/data_i slice k
//   stable until it sees gnt_o[k]. The transfer happens on the rising clock
//   edge where req_i[k] & gnt_o[k] are both high. There is no back-pressure
//   after that edge; the outcome of the write is either a write_perip_o
//   strobe or a one-cycle err_o[k] pulse.
//
//   Signals
//     req_i          requester -> arb  per-requester write request
//     addr_i         requester -> arb  byte addresses, slice k = [32k+31:32k]
//     data_i         requester -> arb  write data, same slicing
//     gnt_o          arb -> requester  one-hot grant (IDLE only)
//     bus_write_i    bus -> arb        bus-side register-file write this cycle
//     bus_addr_i     bus -> arb        bus-side byte address
//     write_perip_o  arb -> regfile    peripheral-port write strobe
//     wraddr_perip_o arb -> regfile    peripheral-port byte address
//     data_perip_o   arb -> regfile    peripheral-port write data
//     err_o          arb -> requester  one-cycle "write dropped" pulse
//     state_dbg_o    arb -> observer   FSM state (0 = IDLE, 1 = ISSUE)
//
//   Modports: slave = arbiter side, master = environment side.
// ---------------------------------------------------------------------------
interface perip_wr_arb_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req_i;
   logic [NREQ*32-1:0] addr_i;
   logic [NREQ*32-1:0] data_i;
   logic [NREQ-1:0]    gnt_o;
   logic               bus_write_i;
   logic [31:0]        bus_addr_i;
   logic               write_perip_o;
   logic [31:0]        wraddr_perip_o;
   logic [31:0]        data_perip_o;
   logic [NREQ-1:0]    err_o;
   logic               state_dbg_o;

   modport slave (
      input  req_i, addr_i, data_i, bus_write_i, bus_addr_i,
      output gnt_o, write_perip_o, wraddr_perip_o, data_perip_o, err_o,
             state_dbg_o
   );

   modport master (
      output req_i, addr_i, data_i, bus_write_i, bus_addr_i,
      input  gnt_o, write_perip_o, wraddr_perip_o, data_perip_o, err_o,
             state_dbg_o
   );
endinterface

// File: rtl/perip_wr_arb.sv
// ---------------------------------------------------------------------------
// perip_wr_arb
//   Round-robin arbiter funnelling NREQ peripheral write requesters into the
//   single peripheral write port of a SIZE-word register file. A granted
//   write is issued one cycle later unless the bus side is writing the same
//   word that cycle (collision), in which case it stalls; after MAX_HOLD
//   stalled cycles, or immediately for an out-of-range word address, the
//   write is dropped and err_o[winner] pulses for one cycle.
//
//   Ports
//     clk_i  clock, all state on rising edge
//     rst_i  asynchronous active-high reset
//     bus    perip_wr_arb_if.slave (requests, grants, regfile port, errors,
//            FSM state debug)
// ---------------------------------------------------------------------------
module perip_wr_arb #(
   parameter int NREQ     = 4,
   parameter int SIZE     = 10,
   parameter int MAX_HOLD = 15
) (
   input  logic           clk_i,
   input  logic           rst_i,
   perip_wr_arb_if.slave  bus
);

   localparam int IDXW = $clog2(NREQ);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDXW-1:0]   rr_ptr_q;
   logic [IDXW-1:0]   winner_q;
   logic [7:0]        hold_q;
   logic [31:0]       wraddr_q;
   logic [31:0]       wdata_q;

   logic [NREQ-1:0]   gnt;
   logic [IDXW-1:0]   win_idx;
   logic              found;
   logic [IDXW:0]     cand;
   logic              collision;
   logic              range_err;
   logic              write_strobe;
   logic              err_pulse;
   logic              hold_inc;
   logic [NREQ-1:0]   err_vec;

   // Word-granular compare: byte offsets within a word do not matter.
   assign collision = bus.bus_write_i & (bus.bus_addr_i[31:2] == wraddr_q[31:2]);
   assign range_err = (wraddr_q[31:2] >= 30'(SIZE));

   // Round-robin pick: scan from rr_ptr upward with wrap-around. Grants are
   // suppressed while reset is held so gnt_o reads 0 during reset.
   always_comb begin
      gnt     = '0;
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      if (state_q == IDLE && !rst_i) begin
         for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) begin
               cand = cand - (IDXW+1)'(NREQ);
            end
            if (!found && bus.req_i[cand[IDXW-1:0]]) begin
               found          = 1'b1;
               win_idx        = cand[IDXW-1:0];
               gnt            = '0;
               gnt[win_idx]   = 1'b1;
            end
         end
      end
   end

   // Next-state and issue-phase outputs. Range error wins over collision.
   always_comb begin
      state_d      = state_q;
      write_strobe = 1'b0;
      err_pulse    = 1'b0;
      hold_inc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (range_err) begin
               err_pulse = 1'b1;
               state_d   = IDLE;
            end else if (collision) begin
               if (hold_q == 8'(MAX_HOLD - 1)) begin
                  err_pulse = 1'b1;
                  state_d   = IDLE;
               end else begin
                  hold_inc  = 1'b1;
               end
            end else begin
               write_strobe = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      err_vec = '0;
      if (err_pulse) begin
         err_vec[winner_q] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         winner_q <= '0;
         hold_q   <= '0;
         wraddr_q <= '0;
         wdata_q  <= '0;
      end else begin
         if (found) begin
            wraddr_q <= bus.addr_i[win_idx*32 +: 32];
            wdata_q  <= bus.data_i[win_idx*32 +: 32];
            winner_q <= win_idx;
            hold_q   <= '0;
            // Next search starts just past the winner so a requester that
            // keeps req_i high waits behind everyone else pending.
            if (win_idx == IDXW'(NREQ - 1)) begin
               rr_ptr_q <= '0;
            end else begin
               rr_ptr_q <= win_idx + 1'b1;
            end
         end else if (hold_inc) begin
            hold_q <= hold_q + 8'd1;
         end
      end
   end

   assign bus.gnt_o          = gnt;
   assign bus.write_perip_o  = write_strobe;
   assign bus.wraddr_perip_o = wraddr_q;
   assign bus.data_perip_o   = wdata_q;
   assign bus.err_o          = err_vec;
   assign bus.state_dbg_o    = state_q;

endmodule

// File: tb/tb_perip_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_perip_wr_arb
//   Directed bench for perip_wr_arb (NREQ=4, SIZE=10, MAX_HOLD=15).
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_perip_wr_arb;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   perip_wr_arb_if #(.NREQ(4)) bus ();

   perip_wr_arb #(
      .NREQ     (4),
      .SIZE     (10),
      .MAX_HOLD (15)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.req_i       = '0;
      bus.addr_i      = '0;
      bus.data_i      = '0;
      bus.bus_write_i = 1'b0;
      bus.bus_addr_i  = '0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      bus.req_i = 4'b1111;
      @(negedge clk);
      #1;
      checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b exp 0000", bus.gnt_o); end
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b exp 0", bus.write_perip_o); end
      checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL reset_err: got %b exp 0000", bus.err_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h0) begin errors++; $display("FAIL reset_wraddr: got %h exp 0", bus.wraddr_perip_o); end
      checks++; if (bus.data_perip_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 0", bus.data_perip_o); end
      checks++; if (bus.state_dbg_o !== 1'b0) begin errors++; $display("FAIL reset_state: got %b exp 0", bus.state_dbg_o); end
      reset_dut();
   endtask

   task automatic test_single();
      bus.req_i          = 4'b0001;
      bus.addr_i[31:0]   = 32'h0000_0008;
      bus.data_i[31:0]   = 32'hDEAD_BEEF;
      #1;
      checks++; if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b exp 0001", bus.gnt_o); end
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL single_idle_write: got %b exp 0", bus.write_perip_o); end
      @(negedge clk);
      bus.req_i = 4'b0000;
      #1;
      checks++; if (bus.write_perip_o !== 1'b1) begin errors++; $display("FAIL single_write: got %b exp 1", bus.write_perip_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h8) begin errors++; $display("FAIL single_wraddr: got %h exp 00000008", bus.wraddr_perip_o); end
      checks++; if (bus.data_perip_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data: got %h exp deadbeef", bus.data_perip_o); end
      checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL single_issue_gnt: got %b exp 0000", bus.gnt_o); end
      @(negedge clk);
      #1;
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL single_after_write: got %b exp 0", bus.write_perip_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h8) begin errors++; $display("FAIL single_hold_wraddr: got %h exp 00000008", bus.wraddr_perip_o); end
      @(negedge clk);
   endtask

   task automatic test_fairness();
      logic [3:0]  exp_gnt;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      reset_dut();
      for (int k = 0; k < 4; k++) begin
         bus.addr_i[k*32 +: 32] = 32'(k * 4);
         bus.data_i[k*32 +: 32] = 32'h1000_0000 + 32'(k);
      end
      bus.req_i = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         exp_gnt  = 4'b0001 << (g % 4);
         exp_addr = 32'((g % 4) * 4);
         exp_data = 32'h1000_0000 + 32'(g % 4);
         #1;
         checks++; if (bus.gnt_o !== exp_gnt) begin errors++; $display("FAIL fair_gnt[%0d]: got %b exp %b", g, bus.gnt_o, exp_gnt); end
         checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL fair_idle_write[%0d]: got %b exp 0", g, bus.write_perip_o); end
         @(negedge clk);
         #1;
         checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL fair_issue_gnt[%0d]: got %b exp 0000", g, bus.gnt_o); end
         checks++; if (bus.write_perip_o !== 1'b1) begin errors++; $display("FAIL fair_write[%0d]: got %b exp 1", g, bus.write_perip_o); end
         checks++; if (bus.wraddr_perip_o !== exp_addr) begin errors++; $display("FAIL fair_wraddr[%0d]: got %h exp %h", g, bus.wraddr_perip_o, exp_addr); end
         checks++; if (bus.data_perip_o !== exp_data) begin errors++; $display("FAIL fair_data[%0d]: got %h exp %h", g, bus.data_perip_o, exp_data); end
         @(negedge clk);
      end
      bus.req_i = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_collision();
      reset_dut();
      bus.req_i          = 4'b0010;
      bus.addr_i[63:32]  = 32'h0000_0010;
      bus.data_i[63:32]  = 32'hA5A5_0001;
      #1;
      checks++; if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL coll_gnt: got %b exp 0010", bus.gnt_o); end
      @(negedge clk);
      bus.req_i       = 4'b0000;
      bus.bus_write_i = 1'b1;
      bus.bus_addr_i  = 32'h0000_0013;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL coll_stall_write[%0d]: got %b exp 0", c, bus.write_perip_o); end
         checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL coll_stall_err[%0d]: got %b exp 0000", c, bus.err_o); end
         @(negedge clk);
      end
      bus.bus_write_i = 1'b0;
      #1;
      checks++; if (bus.write_perip_o !== 1'b1) begin errors++; $display("FAIL coll_commit: got %b exp 1", bus.write_perip_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h10) begin errors++; $display("FAIL coll_wraddr: got %h exp 00000010", bus.wraddr_perip_o); end
      checks++; if (bus.data_perip_o !== 32'hA5A5_0001) begin errors++; $display("FAIL coll_data: got %h exp a5a50001", bus.data_perip_o); end
      @(negedge clk);
      // Neighbouring word on the bus must not stall.
      bus.req_i         = 4'b0010;
      bus.data_i[63:32] = 32'h5A5A_0002;
      bus.bus_write_i   = 1'b1;
      bus.bus_addr_i    = 32'h0000_0014;
      #1;
      checks++; if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL nostall_gnt: got %b exp 0010", bus.gnt_o); end
      @(negedge clk);
      bus.req_i = 4'b0000;
      #1;
      checks++; if (bus.write_perip_o !== 1'b1) begin errors++; $display("FAIL nostall_write: got %b exp 1", bus.write_perip_o); end
      checks++; if (bus.data_perip_o !== 32'h5A5A_0002) begin errors++; $display("FAIL nostall_data: got %h exp 5a5a0002", bus.data_perip_o); end
      @(negedge clk);
      bus.bus_write_i = 1'b0;
   endtask

   task automatic test_timeout();
      logic [3:0] exp_err;
      reset_dut();
      bus.req_i          = 4'b0100;
      bus.addr_i[95:64]  = 32'h0000_0020;
      bus.data_i[95:64]  = 32'h0BAD_F00D;
      bus.bus_write_i    = 1'b1;
      bus.bus_addr_i     = 32'h0000_0020;
      #1;
      checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL tmo_gnt: got %b exp 0100", bus.gnt_o); end
      @(negedge clk);
      bus.req_i = 4'b0000;
      for (int n = 1; n <= 15; n++) begin
         exp_err = (n == 15) ? 4'b0100 : 4'b0000;
         #1;
         checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL tmo_write[%0d]: got %b exp 0", n, bus.write_perip_o); end
         checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL tmo_err[%0d]: got %b exp %b", n, bus.err_o, exp_err); end
         @(negedge clk);
      end
      #1;
      checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL tmo_err_after: got %b exp 0000", bus.err_o); end
      checks++; if (bus.state_dbg_o !== 1'b0) begin errors++; $display("FAIL tmo_state_idle: got %b exp 0", bus.state_dbg_o); end
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL tmo_write_after: got %b exp 0", bus.write_perip_o); end
      bus.bus_write_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_range();
      reset_dut();
      // Word 10 is one past the end of a 10-word file.
      bus.req_i           = 4'b1000;
      bus.addr_i[127:96]  = 32'h0000_0028;
      bus.data_i[127:96]  = 32'h1111_2222;
      #1;
      checks++; if (bus.gnt_o !== 4'b1000) begin errors++; $display("FAIL range_gnt: got %b exp 1000", bus.gnt_o); end
      @(negedge clk);
      bus.req_i = 4'b0000;
      #1;
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL range_write: got %b exp 0", bus.write_perip_o); end
      checks++; if (bus.err_o !== 4'b1000) begin errors++; $display("FAIL range_err: got %b exp 1000", bus.err_o); end
      @(negedge clk);
      #1;
      checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL range_err_after: got %b exp 0000", bus.err_o); end
      // Out of range and colliding: the range error is reported at once.
      bus.req_i       = 4'b1000;
      bus.bus_write_i = 1'b1;
      bus.bus_addr_i  = 32'h0000_0028;
      @(negedge clk);
      bus.req_i = 4'b0000;
      #1;
      checks++; if (bus.err_o !== 4'b1000) begin errors++; $display("FAIL range_prec_err: got %b exp 1000", bus.err_o); end
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL range_prec_write: got %b exp 0", bus.write_perip_o); end
      @(negedge clk);
      bus.bus_write_i = 1'b0;
      // Word 9 is the last valid word.
      bus.req_i          = 4'b1000;
      bus.addr_i[127:96] = 32'h0000_0024;
      @(negedge clk);
      bus.req_i = 4'b0000;
      #1;
      checks++; if (bus.write_perip_o !== 1'b1) begin errors++; $display("FAIL range_last_write: got %b exp 1", bus.write_perip_o); end
      checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL range_last_err: got %b exp 0000", bus.err_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h24) begin errors++; $display("FAIL range_last_wraddr: got %h exp 00000024", bus.wraddr_perip_o); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_issue();
      reset_dut();
      bus.req_i          = 4'b0001;
      bus.addr_i[31:0]   = 32'h0000_0004;
      bus.data_i[31:0]   = 32'h7777_0000;
      @(negedge clk);
      // Advance the pointer past 0 so the reset's effect on it is visible.
      bus.req_i          = 4'b0100;
      bus.addr_i[95:64]  = 32'h0000_0008;
      bus.data_i[95:64]  = 32'h3333_4444;
      @(negedge clk);
      #1;
      checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL rstmid_gnt: got %b exp 0100", bus.gnt_o); end
      @(negedge clk);
      bus.req_i       = 4'b0101;
      bus.bus_write_i = 1'b0;
      rst             = 1'b1;
      #1;
      checks++; if (bus.write_perip_o !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b exp 0", bus.write_perip_o); end
      checks++; if (bus.err_o !== 4'b0000) begin errors++; $display("FAIL rstmid_err: got %b exp 0000", bus.err_o); end
      checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt_rst: got %b exp 0000", bus.gnt_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h0) begin errors++; $display("FAIL rstmid_wraddr: got %h exp 0", bus.wraddr_perip_o); end
      checks++; if (bus.data_perip_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h exp 0", bus.data_perip_o); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL rstmid_next_gnt: got %b exp 0001", bus.gnt_o); end
      @(negedge clk);
      bus.req_i = 4'b0000;
      #1;
      checks++; if (bus.write_perip_o !== 1'b1) begin errors++; $display("FAIL rstmid_next_write: got %b exp 1", bus.write_perip_o); end
      checks++; if (bus.wraddr_perip_o !== 32'h4) begin errors++; $display("FAIL rstmid_next_wraddr: got %h exp 00000004", bus.wraddr_perip_o); end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_fairness();
      test_collision();
      test_timeout();
      test_range();
      test_reset_mid_issue();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/perip_wr_arb.md
PERIP_WR_ARB -- requirements
Module: perip_wr_arb

Interface
REQ-001 Parameter NREQ, default 4, number of peripheral write requesters (2..8).
REQ-002 Parameter SIZE, default 10, number of 32-bit words in the target peripheral register file.
REQ-003 Parameter MAX_HOLD, default 15, maximum consecutive collision-stalled cycles before a write is dropped (1..255).
REQ-004 clk_i  input  1  sole clock, all state on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_i  input  NREQ  per-requester write request; addr/data held stable while high and not granted.
REQ-007 addr_i  input  NREQ*32  per-requester byte address, slice k = [32k+31:32k].
REQ-008 data_i  input  NREQ*32  per-requester write data, same slicing.
REQ-009 gnt_o  output  NREQ  one-hot grant; transfer occurs on the edge where req_i[k] & gnt_o[k].
REQ-010 bus_write_i  input  1  bus-side write to the register file this cycle.
REQ-011 bus_addr_i  input  32  bus-side byte address.
REQ-012 write_perip_o  output  1  peripheral-port write strobe to the register file.
REQ-013 wraddr_perip_o  output  32  peripheral-port write byte address.
REQ-014 data_perip_o  output  32  peripheral-port write data.
REQ-015 err_o  output  NREQ  one-cycle pulse per requester: its accepted write was dropped.

Function
REQ-016 States: IDLE, ISSUE; held in a registered state variable.
REQ-017 IDLE: if any req_i high, gnt_o SHALL assert combinationally for exactly one requester, chosen round-robin starting at pointer rr_ptr; else gnt_o=0.
REQ-018 gnt_o SHALL be 0 in any state other than IDLE; req_i ignored in ISSUE.
REQ-019 On a grant edge: latch addr_i/data_i of the winner into wraddr_perip_o/data_perip_o registers, record winner index, rr_ptr <= (winner+1) mod NREQ, hold counter <= 0, state <= ISSUE.
REQ-020 Collision = bus_write_i & (bus_addr_i[31:2] == wraddr_perip_o[31:2]), evaluated combinationally.
REQ-021 Range error = wraddr_perip_o[31:2] >= SIZE.
REQ-022 ISSUE, no collision, no range error: write_perip_o=1 this cycle; state <= IDLE at next edge.
REQ-023 ISSUE, collision: write_perip_o=0; hold counter increments; remain in ISSUE.
REQ-024 ISSUE, collision and hold counter == MAX_HOLD-1: write_perip_o=0, err_o[winner] pulses one cycle, state <= IDLE (write dropped).
REQ-025 ISSUE, range error: write_perip_o=0, err_o[winner] pulses one cycle, state <= IDLE; range error takes precedence over collision.
REQ-026 write_perip_o SHALL be 0 in IDLE; wraddr_perip_o/data_perip_o hold last latched values outside grants.
REQ-027 Minimum spacing between accepted grants is 2 cycles; sustained throughput one write per 2 cycles absent collisions.
REQ-028 Collision with a different word address, or bus_write_i=0, SHALL never stall.
REQ-029 A requester keeping req_i high after its grant SHALL be re-arbitrated fairly (other pending requesters served first).
REQ-030 err_o SHALL never assert for more than one requester in a cycle nor for more than one cycle per accepted write.

Reset
REQ-031 While rst_i high: state=IDLE, rr_ptr=0, hold counter=0, winner=0, gnt_o=0, write_perip_o=0, wraddr_perip_o=0, data_perip_o=0, err_o=0.
REQ-032 rst_i asserted during ISSUE SHALL abandon the pending write with no write_perip_o and no err_o pulse; first post-reset arbitration starts at requester 0.

Verification
REQ-033 Single: req_i=0001, addr_i[0]=0x8, data 0xDEADBEEF -> gnt_o=0001 cycle 0; cycle 1 write_perip_o=1, wraddr 0x8, data 0xDEADBEEF.
REQ-034 Fairness: req_i=1111 held for 8 grants from reset -> grant order 0,1,2,3,0,1,2,3, grants every 2 cycles.
REQ-035 Collision: requester 1 writes 0x10 while bus_write_i=1, bus_addr 0x13 for 3 cycles -> write_perip_o low 3 cycles, commits on 4th ISSUE cycle; bus_addr 0x14 -> no stall.
REQ-036 Timeout: MAX_HOLD=15, continuous colliding bus write -> err_o[k] single pulse on 15th stalled cycle, no write_perip_o, back to IDLE.
REQ-037 Range: addr 0x28 (word 10, SIZE=10) -> no write_perip_o, err_o[k] pulse in ISSUE cycle.
REQ-038 Reset mid-ISSUE: rst_i pulse in ISSUE -> all outputs 0 immediately, no write, no err, next grant to lowest pending index.
